ps2_key_decoder: RTL
====================

// Module: ps2_key_decoder
// PURPOSE
//  Consumes the byte stream of the PS/2 receive stage: one scan-code byte plus a 1-cycle valid strobe.
//  Resolves make, break (F0) and extended (E0) sequences into a held-key state, an ASCII code and a press count.
//  Drives six 7-segment digits for the board: scan code, ASCII and count.
// PARAMETERS
//  CNT_W      8  width of press counter (display shows low 8 bits)
//  SEG_ACT_LO 1  1: segment outputs active-low, 0: active-high
// PORTS
//  clk        in   1  single system clock
//  resetn     in   1  synchronous, active-low reset
//  kb_data    in   8  received scan-code byte, parity already checked
//  kb_valid   in   1  1-cycle strobe; kb_data is consumed that cycle, no backpressure
//  key_down   out  1  a key is currently held
//  key_ext    out  1  held key was E0-prefixed
//  key_code   out  8  scan code of held key
//  key_ascii  out  8  ASCII of held key, 8'h00 if unmapped or extended
//  press_cnt  out  CNT_W  count of distinct key presses
//  hex0..hex5 out  7  segments {g,f,e,d,c,b,a}: hex1:0 code, hex3:2 ascii, hex5:4 press_cnt[7:0]
// BEHAVIOUR
//  Reset (resetn=0 at a clk edge): FSM=IDLE. key_down, key_ext, key_code, key_ascii and press_cnt all 0.
//    hex0-3 blank, hex4/5 show "0". A reset mid-sequence discards the pending prefix.
//  All outputs are registered and update on the clk edge after the one where kb_valid=1 (latency 1).
//  kb_valid=0: nothing changes. Bytes never arrive back-to-back faster than 1/clk.
//  FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
//    IDLE:    E0 -> EXT; F0 -> BRK; other byte -> make(code, ext=0), stay IDLE.
//    EXT:     F0 -> EXT_BRK; E0 -> EXT; other byte -> make(code, ext=1) -> IDLE.
//    BRK:     F0 -> BRK; E0 -> EXT_BRK; other byte -> brk(code, ext=0) -> IDLE.
//    EXT_BRK: F0/E0 -> stay; other byte -> brk(code, ext=1) -> IDLE.
//  make(c,e):
//    - if key_down and {e,c}=={key_ext,key_code}: typematic repeat, no change, press_cnt held.
//    - else: key_down=1, key_code=c, key_ext=e, key_ascii=ascii(c) (00 if e=1),
//      press_cnt+1. The counter wraps from all-ones to 0.
//    - a new make while another key is held replaces it (last-key-wins).
//  brk(c,e): if {e,c} matches held key -> key_down=0, key_code/key_ascii/key_ext keep last value.
//    A non-matching break is ignored.
//  Display:
//    - key_down=0 -> hex0-3 blank (all segments off per SEG_ACT_LO).
//    - hex4/5 always show press_cnt[7:0] as hex.
//  ASCII table: set 2 codes for a-z (lowercase), 0-9, space(29), enter(5A->0D); all others 00.
// CONFIGURATION
//  PS2_SHIFT_EN defined:
//    - L-shift (12) and R-shift (59) tracked as a separate shift_held flag: make sets it, matching break clears it.
//    - shift bytes don't count, don't change key_code, don't affect the held key.
//    - while shift_held, letters map to uppercase and digits to shifted US symbols (1->'!', 2->'@', ...).
//  PS2_SHIFT_EN undefined: 12/59 are ordinary unmapped keys (counted, ascii 00); lowercase only.
// STRUCTURE
//  Package ps2_pkg: FSM state enum, constants PS2_BRK=8'hF0 and PS2_EXT=8'hE0, shift codes,
//    function ps2_ascii(code, shift) implemented as a case table.
//  Sub-module seg7_hex (4-bit nibble, blank, active-low param -> 7 segments), instantiated 6x.
// TESTING
//  1. Reset, then bytes 1C, F0, 1C -> key_down 1 with code 1C, ascii 61 ('a'), cnt 1; after the break key_down 0 and hex0-3 blank.
//  2. 1C,1C,1C (typematic) then F0,1C -> cnt stays 1; key_down drops only after the final 1C.
//  3. E0,75,E0,F0,75 -> key_ext 1, code 75, ascii 00, cnt+1; then key_down 0.
//  4. 1C then 32 then F0,1C -> code 32 held, cnt+2, stray break ignored; F0,32 releases it.
//  5. Preload cnt 255 via 255 distinct presses, one more press -> press_cnt 0, hex5/4 show "00".
//  6. Reset asserted after F0 mid-sequence, then 1C -> treated as a make in IDLE, cnt 1.
//  7. PS2_SHIFT_EN: 12,1C -> ascii 41 ('A'), cnt 1; F0,12, then F0,1C, then 1C -> ascii 61.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 decoder definitions: FSM states, prefix/shift scan codes and
// the set-2 scan-code to ASCII lookup.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } ps2_state_t;

    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    function automatic logic [7:0] ps2_ascii(input logic [7:0] code, input logic shift);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
            8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
            8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
            8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
            8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h29: a = 8'h20;
            8'h5A: a = 8'h0D;
            default: a = 8'h00;
        endcase
        // Shift acts on the resolved character: letters upper-case, digits to US symbols.
        if (shift) begin
            if (a >= 8'h61 && a <= 8'h7A) begin
                a = a - 8'h20;
            end else begin
                case (a)
                    8'h30: a = 8'h29; 8'h31: a = 8'h21; 8'h32: a = 8'h40; 8'h33: a = 8'h23;
                    8'h34: a = 8'h24; 8'h35: a = 8'h25; 8'h36: a = 8'h5E; 8'h37: a = 8'h26;
                    8'h38: a = 8'h2A; 8'h39: a = 8'h28;
                    default: a = a;
                endcase
            end
        end
        return a;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_seg7_hex.sv
// Hex nibble to 7-segment {g,f,e,d,c,b,a} decoder with blanking and
// selectable output polarity.
module seg7_hex #(
    parameter bit ACT_LO = 1'b1
) (
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] seg_on;

    always_comb begin
        seg_on = 7'h00;
        case (nibble)
            4'h0: seg_on = 7'h3F; 4'h1: seg_on = 7'h06; 4'h2: seg_on = 7'h5B; 4'h3: seg_on = 7'h4F;
            4'h4: seg_on = 7'h66; 4'h5: seg_on = 7'h6D; 4'h6: seg_on = 7'h7D; 4'h7: seg_on = 7'h07;
            4'h8: seg_on = 7'h7F; 4'h9: seg_on = 7'h6F; 4'hA: seg_on = 7'h77; 4'hB: seg_on = 7'h7C;
            4'hC: seg_on = 7'h39; 4'hD: seg_on = 7'h5E; 4'hE: seg_on = 7'h79; 4'hF: seg_on = 7'h71;
            default: seg_on = 7'h00;
        endcase
        if (blank) begin
            seg_on = 7'h00;
        end
        seg = ACT_LO ? ~seg_on : seg_on;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: make/break/extended tracking, ASCII, press count
// and six 7-segment digits. Define PS2_SHIFT_EN to enable shift-key handling.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter bit SEG_ACT_LO = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       kb_data,
    input  logic             kb_valid,
    output logic             key_down,
    output logic             key_ext,
    output logic [7:0]       key_code,
    output logic [7:0]       key_ascii,
    output logic [CNT_W-1:0] press_cnt,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [6:0]       hex4,
    output logic [6:0]       hex5
);

    ps2_state_t       state_reg, state_next;
    logic             key_down_reg, key_down_next;
    logic             key_ext_reg, key_ext_next;
    logic [7:0]       key_code_reg, key_code_next;
    logic [7:0]       key_ascii_reg, key_ascii_next;
    logic [CNT_W-1:0] press_cnt_reg, press_cnt_next;
    logic             shift_held_reg, shift_held_next;

    logic             do_make, do_brk, ev_ext, is_shift, same_key;

`ifdef PS2_SHIFT_EN
    assign is_shift = !ev_ext && (kb_data == PS2_LSHIFT || kb_data == PS2_RSHIFT);
`else
    assign is_shift = 1'b0;
`endif
    assign same_key = key_down_reg && ({ev_ext, kb_data} == {key_ext_reg, key_code_reg});

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            key_down_reg   <= 1'b0;
            key_ext_reg    <= 1'b0;
            key_code_reg   <= 8'h00;
            key_ascii_reg  <= 8'h00;
            press_cnt_reg  <= '0;
            shift_held_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            key_down_reg   <= key_down_next;
            key_ext_reg    <= key_ext_next;
            key_code_reg   <= key_code_next;
            key_ascii_reg  <= key_ascii_next;
            press_cnt_reg  <= press_cnt_next;
            shift_held_reg <= shift_held_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        key_down_next   = key_down_reg;
        key_ext_next    = key_ext_reg;
        key_code_next   = key_code_reg;
        key_ascii_next  = key_ascii_reg;
        press_cnt_next  = press_cnt_reg;
        shift_held_next = shift_held_reg;
        do_make         = 1'b0;
        do_brk          = 1'b0;
        ev_ext          = 1'b0;

        if (kb_valid) begin
            case (state_reg)
                ST_IDLE: begin
                    if (kb_data == PS2_EXT)      state_next = ST_EXT;
                    else if (kb_data == PS2_BRK) state_next = ST_BRK;
                    else                         do_make = 1'b1;
                end
                ST_EXT: begin
                    ev_ext = 1'b1;
                    if (kb_data == PS2_BRK)      state_next = ST_EXT_BRK;
                    else if (kb_data != PS2_EXT) begin
                        do_make    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (kb_data == PS2_EXT)      state_next = ST_EXT_BRK;
                    else if (kb_data != PS2_BRK) begin
                        do_brk     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    ev_ext = 1'b1;
                    if (kb_data != PS2_BRK && kb_data != PS2_EXT) begin
                        do_brk     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            endcase
        end

        // Shift keys live outside the held-key slot so they never count or replace a key.
        if (do_make) begin
            if (is_shift) begin
                shift_held_next = 1'b1;
            end else if (!same_key) begin
                key_down_next  = 1'b1;
                key_code_next  = kb_data;
                key_ext_next   = ev_ext;
                key_ascii_next = ev_ext ? 8'h00 : ps2_ascii(kb_data, shift_held_reg);
                press_cnt_next = press_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
        if (do_brk) begin
            if (is_shift)      shift_held_next = 1'b0;
            else if (same_key) key_down_next   = 1'b0;
        end
    end

    assign key_down  = key_down_reg;
    assign key_ext   = key_ext_reg;
    assign key_code  = key_code_reg;
    assign key_ascii = key_ascii_reg;
    assign press_cnt = press_cnt_reg;

    logic [7:0] cnt_low;
    generate
        if (CNT_W >= 8) begin : g_cnt_wide
            assign cnt_low = press_cnt_reg[7:0];
        end else begin : g_cnt_narrow
            assign cnt_low = {{(8-CNT_W){1'b0}}, press_cnt_reg};
        end
    endgenerate

    logic [3:0] nib [6];
    logic [6:0] seg [6];
    assign nib[0] = key_code_reg[3:0];
    assign nib[1] = key_code_reg[7:4];
    assign nib[2] = key_ascii_reg[3:0];
    assign nib[3] = key_ascii_reg[7:4];
    assign nib[4] = cnt_low[3:0];
    assign nib[5] = cnt_low[7:4];

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            // Count digits stay lit; code/ascii digits go dark when no key is held.
            seg7_hex #(.ACT_LO(SEG_ACT_LO)) u_seg (
                .nibble (nib[gi]),
                .blank  ((gi < 4) && !key_down_reg),
                .seg    (seg[gi])
            );
        end
    endgenerate

    assign hex0 = seg[0];
    assign hex1 = seg[1];
    assign hex2 = seg[2];
    assign hex3 = seg[3];
    assign hex4 = seg[4];
    assign hex5 = seg[5];

endmodule
